sprite_addr_cal: RTL and testbench

Per-pixel sprite address generator for the sprite display blocks, one instance per sprite slot. From a pattern descriptor, a sprite state word and the current raster position, it decides whether the pixel lies inside the sprite. If it does, it computes the pattern-memory address of the texel to show. The owning display block looks up the texel colour and gates it with `valid`.

---
 rtl/sprite_addr_cal_pkg.sv | 21 ++
 rtl/sprite_addr_cal_if.sv | 16 +
 rtl/sprite_addr_cal_scale_decode.sv | 25 ++
 rtl/sprite_addr_cal.sv | 59 +++++
 tb/tb_sprite_addr_cal.sv | 148 ++++++++++++++
 5 files changed

// File: rtl/sprite_addr_cal_pkg.sv
// Shared types for the sprite address path: descriptor layouts and widths.
package sprite_pkg;
  localparam int ADDR_W  = 16;
  localparam int COORD_W = 10;

  typedef struct packed {
    logic [15:0] base;
    logic [15:0] pw;
    logic [15:0] ph;
    logic [15:0] dw;
    logic [15:0] dh;
  } pattern_info_t;

  typedef struct packed {
    logic       visible;
    logic       flip;
    logic [9:0] x;
    logic [9:0] y;
    logic [9:0] shift;
  } sprite_info_t;
endpackage

// File: rtl/sprite_addr_cal_if.sv
// Per-slot sprite bus: descriptor and raster position in, texel address out.
interface sprite_addr_cal_if
  import sprite_pkg::*;
();
  pattern_info_t      pattern_info;
  sprite_info_t       sprite_info;
  logic [COORD_W-1:0] hcount;
  logic [COORD_W-1:0] vcount;
  logic [ADDR_W-1:0]  addr_output;
  logic               valid;

  modport master (output pattern_info, sprite_info, hcount, vcount,
                  input  addr_output, valid);
  modport slave  (input  pattern_info, sprite_info, hcount, vcount,
                  output addr_output, valid);
endinterface

// File: rtl/sprite_addr_cal_scale_decode.sv
// Finds the power-of-two magnification k (0..3) shared by both axes.
module scale_decode
  import sprite_pkg::*;
(
  input  logic [15:0] pw_i,
  input  logic [15:0] ph_i,
  input  logic [15:0] dw_i,
  input  logic [15:0] dh_i,
  output logic [1:0]  k_o,
  output logic        legal_o
);
  always_comb begin
    k_o     = '0;
    legal_o = 1'b0;
    // Widened compare so pw<<k cannot alias back into range.
    for (int k = 0; k < 4; k++) begin
      if (({3'b0, dw_i} == ({3'b0, pw_i} << k)) &&
          ({3'b0, dh_i} == ({3'b0, ph_i} << k))) begin
        k_o     = 2'(k);
        legal_o = 1'b1;
      end
    end
    if (pw_i == '0 || ph_i == '0) legal_o = 1'b0;
  end
endmodule

// File: rtl/sprite_addr_cal.sv
// One-stage sprite texel address generator; one instance per sprite slot.
module sprite_addr_cal
  import sprite_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  sprite_addr_cal_if.slave  bus
);
  pattern_info_t     pat;
  sprite_info_t      spr;
  logic signed [11:0] left, col, row;
  logic [1:0]        k;
  logic              legal, in_col, in_row;
  logic [15:0]       pc_raw, pc, pr, prod;
  logic [ADDR_W-1:0] addr_d, addr_q;
  logic              valid_d, valid_q;

  assign pat = bus.pattern_info;
  assign spr = bus.sprite_info;

  scale_decode u_scale (
    .pw_i   (pat.pw),
    .ph_i   (pat.ph),
    .dw_i   (pat.dw),
    .dh_i   (pat.dh),
    .k_o    (k),
    .legal_o(legal)
  );

  // Negative left edge means the sprite hangs off the left of the screen.
  assign left = $signed({2'b0, spr.x}) - $signed({2'b0, spr.shift});
  assign col  = $signed({2'b0, bus.hcount}) - left;
  assign row  = $signed({2'b0, bus.vcount}) - $signed({2'b0, spr.y});

  assign in_col = !col[11] && ({5'b0, col[10:0]} < pat.dw);
  assign in_row = !row[11] && ({5'b0, row[10:0]} < pat.dh);

  assign pc_raw = {5'b0, col[10:0]} >> k;
  assign pr     = {5'b0, row[10:0]} >> k;
  assign pc     = spr.flip ? (pat.pw - 16'd1 - pc_raw) : pc_raw;

  // Product and sum wrap at 16 bits; range checking is the consumer's job.
  assign prod   = pr * pat.pw;
  assign valid_d = spr.visible && in_col && in_row && legal;
  assign addr_d  = valid_d ? (pat.base + prod + pc) : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      valid_q <= valid_d;
    end
  end

  assign bus.addr_output = addr_q;
  assign bus.valid       = valid_q;
endmodule

// File: tb/tb_sprite_addr_cal.sv
// Directed and randomized checks of sprite_addr_cal against an arithmetic model.
module tb_sprite_addr_cal;
  import sprite_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int failures = 0;

  pattern_info_t pat;
  sprite_info_t  spr;
  logic [9:0]    hc, vc;

  sprite_addr_cal_if bus ();
  assign bus.pattern_info = pat;
  assign bus.sprite_info  = spr;
  assign bus.hcount       = hc;
  assign bus.vcount       = vc;

  sprite_addr_cal dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic ev, input logic [15:0] ea);
    checks++;
    assert (bus.valid === ev) else begin
      failures++;
      $error("FAIL %s valid got=%b exp=%b", tag, bus.valid, ev);
    end
    checks++;
    assert (bus.addr_output === ea) else begin
      failures++;
      $error("FAIL %s addr got=%h exp=%h", tag, bus.addr_output, ea);
    end
  endtask

  // Clock the current inputs through, then sample away from the edge.
  task automatic run(input string tag, input logic ev, input logic [15:0] ea);
    @(posedge clk);
    #1;
    chk(tag, ev, ea);
  endtask

  function automatic void model(input pattern_info_t p, input sprite_info_t s,
                                input logic [9:0] h, input logic [9:0] v,
                                output logic ev, output logic [15:0] ea);
    longint left, col, row, k, pc, pr, scale;
    k = -1;
    for (int i = 0; i < 4; i++)
      if (p.pw != 0 && p.ph != 0 &&
          longint'(p.dw) == longint'(p.pw) * (2 ** i) &&
          longint'(p.dh) == longint'(p.ph) * (2 ** i))
        k = i;
    left = longint'(s.x) - longint'(s.shift);
    col  = longint'(h) - left;
    row  = longint'(v) - longint'(s.y);
    ev = s.visible && k >= 0 && col >= 0 && col < longint'(p.dw) &&
         row >= 0 && row < longint'(p.dh);
    ea = 16'h0;
    if (ev) begin
      scale = 2 ** k;
      pc = col / scale;
      pr = row / scale;
      if (s.flip) pc = longint'(p.pw) - 1 - pc;
      ea = 16'((longint'(p.base) + pr * longint'(p.pw) + pc) % 65536);
    end
  endfunction

  task automatic set_pat(input int b, input int w, input int h, input int dw, input int dh);
    pat = '{base: 16'(b), pw: 16'(w), ph: 16'(h), dw: 16'(dw), dh: 16'(dh)};
  endtask

  task automatic set_spr(input logic vis, input logic fl, input int x, input int y, input int sh);
    spr = '{visible: vis, flip: fl, x: 10'(x), y: 10'(y), shift: 10'(sh)};
  endtask

  initial begin
    logic ev;
    logic [15:0] ea;
    set_pat(128, 8, 16, 8, 16);
    set_spr(1'b1, 1'b0, 100, 50, 0);
    hc = 10'd103; vc = 10'd52;
    #1 reset = 1'b1;
    #2 chk("reset_state", 1'b0, 16'h0);
    @(negedge clk) reset = 1'b0;

    run("cover_in", 1'b1, 16'd147);
    hc = 10'd108; run("cover_out", 1'b0, 16'h0);

    set_spr(1'b1, 1'b1, 100, 50, 0);
    hc = 10'd103; run("flip_103", 1'b1, 16'd148);
    hc = 10'd100; run("flip_100", 1'b1, 16'd151);

    set_spr(1'b1, 1'b0, 100, 50, 0);
    set_pat(128, 8, 16, 16, 32);
    hc = 10'd105; vc = 10'd59; run("scale_k1", 1'b1, 16'd162);
    set_pat(128, 8, 16, 12, 16);
    run("scale_illegal", 1'b0, 16'h0);
    set_pat(128, 0, 16, 0, 16);
    hc = 10'd100; vc = 10'd50; run("pw_zero", 1'b0, 16'h0);

    set_pat(128, 8, 16, 8, 16);
    set_spr(1'b1, 1'b0, 2, 50, 5);
    hc = 10'd0; vc = 10'd52; run("left_clip", 1'b1, 16'd147);

    set_spr(1'b0, 1'b0, 100, 50, 0);
    hc = 10'd103; run("invisible", 1'b0, 16'h0);

    set_spr(1'b1, 1'b0, 100, 50, 0);
    hc = 10'd107; run("col_last", 1'b1, 16'd151);
    hc = 10'd108; run("col_past", 1'b0, 16'h0);
    hc = 10'd103; vc = 10'd65; run("row_last", 1'b1, 16'd251);
    vc = 10'd66; run("row_past", 1'b0, 16'h0);

    set_pat(16'hFFF0, 8, 16, 8, 16);
    hc = 10'd100; vc = 10'd54; run("addr_wrap", 1'b1, 16'h0010);

    // Mid-frame reset: clears at once, holds, recovers one edge after release.
    set_pat(128, 8, 16, 8, 16);
    hc = 10'd103; vc = 10'd52; run("pre_reset", 1'b1, 16'd147);
    #2 reset = 1'b1;
    #1 chk("reset_async", 1'b0, 16'h0);
    @(posedge clk); #1 chk("reset_hold", 1'b0, 16'h0);
    reset = 1'b0;
    #1 chk("reset_release", 1'b0, 16'h0);
    run("post_reset", 1'b1, 16'd147);

    for (int n = 0; n < 400; n++) begin
      int pw, ph, k, x, y, sh;
      pw = $urandom_range(1, 20);
      ph = $urandom_range(1, 20);
      k  = $urandom_range(0, 3);
      x  = $urandom_range(0, 639);
      y  = $urandom_range(0, 479);
      sh = $urandom_range(0, 15);
      set_pat($urandom_range(0, 65535), pw, ph,
              ($urandom_range(0, 7) == 0) ? pw * 3 : (pw << k), ph << k);
      set_spr($urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)), x, y, sh);
      hc = 10'(x - sh + int'($urandom_range(0, 170)) - 4);
      vc = 10'(y + int'($urandom_range(0, 170)) - 4);
      model(pat, spr, hc, vc, ev, ea);
      run("random", ev, ea);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
